// File: rtl/alu_bus_master_if.sv
// Wishbone pipelined bus between the ALU bus master and the ALU slave.
// Signal names are seen from the master side (o_ = driven by master).
interface alu_bus_master_if;
   logic       o_wb_cyc;
   logic       o_wb_stb;
   logic       o_wb_we;
   logic [7:0] o_wb_addr;
   logic [7:0] o_wb_data;
   logic       i_wb_ack;
   logic       i_wb_stall;
   logic [7:0] i_wb_data;

   modport master (
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
      input  i_wb_ack, i_wb_stall, i_wb_data
   );

   modport slave (
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
      output i_wb_ack, i_wb_stall, i_wb_data
   );
endinterface

// File: rtl/alu_bus_master.sv
// Turns one ALU request into a Wishbone sequence (write A, write B, read result)
// and returns the read byte, or a timeout error, on a valid/ready response port.
module alu_bus_master #(
   parameter int TIMEOUT = 16
) (
   input  logic             i_clk,
   input  logic             reset,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [7:0]       i_req_a,
   input  logic [7:0]       i_req_b,
   input  logic [1:0]       i_req_wmask,
   input  logic [7:0]       i_req_raddr,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [7:0]       o_rsp_data,
   output logic             o_rsp_err,
   alu_bus_master_if.master wb
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t     state_q, state_d;

   logic       q_we_q   [3];
   logic       q_we_d   [3];
   logic [7:0] q_addr_q [3];
   logic [7:0] q_addr_d [3];
   logic [7:0] q_data_q [3];
   logic [7:0] q_data_d [3];

   logic [1:0] n_req_q, n_req_d;
   logic [1:0] issue_idx_q, issue_idx_d;
   logic [1:0] ack_cnt_q, ack_cnt_d;
   logic [7:0] tmo_q, tmo_d;

   logic       cyc_q, cyc_d;
   logic       stb_q, stb_d;
   logic       we_q, we_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_err_q, rsp_err_d;

   // Transfer list built from the incoming request, before it is latched.
   logic       slot_we   [3];
   logic [7:0] slot_addr [3];
   logic [7:0] slot_data [3];
   logic [1:0] slot_b_idx;
   logic [1:0] slot_r_idx;

   logic [1:0] next_idx;
   logic [1:0] ack_cnt_inc;
   logic [7:0] tmo_inc;

   assign next_idx    = issue_idx_q + 2'd1;
   assign ack_cnt_inc = ack_cnt_q + 2'd1;
   assign tmo_inc     = tmo_q + 8'd1;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         slot_we[i]   = 1'b0;
         slot_addr[i] = 8'h00;
         slot_data[i] = 8'h00;
      end
      slot_b_idx = {1'b0, i_req_wmask[0]};
      slot_r_idx = 2'(i_req_wmask[0]) + 2'(i_req_wmask[1]);

      if (i_req_wmask[0]) begin
         slot_we[0]   = 1'b1;
         slot_addr[0] = 8'h00;
         slot_data[0] = i_req_a;
      end
      if (i_req_wmask[1]) begin
         slot_we[slot_b_idx]   = 1'b1;
         slot_addr[slot_b_idx] = 8'h01;
         slot_data[slot_b_idx] = i_req_b;
      end
      slot_addr[slot_r_idx] = i_req_raddr;
   end

   always_comb begin
      state_d     = state_q;
      for (int i = 0; i < 3; i++) begin
         q_we_d[i]   = q_we_q[i];
         q_addr_d[i] = q_addr_q[i];
         q_data_d[i] = q_data_q[i];
      end
      n_req_d     = n_req_q;
      issue_idx_d = issue_idx_q;
      ack_cnt_d   = ack_cnt_q;
      tmo_d       = tmo_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               for (int i = 0; i < 3; i++) begin
                  q_we_d[i]   = slot_we[i];
                  q_addr_d[i] = slot_addr[i];
                  q_data_d[i] = slot_data[i];
               end
               n_req_d     = slot_r_idx + 2'd1;
               issue_idx_d = 2'd0;
               ack_cnt_d   = 2'd0;
               tmo_d       = 8'd0;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               we_d        = slot_we[0];
               addr_d      = slot_addr[0];
               wdata_d     = slot_data[0];
               state_d     = ISSUE;
            end
         end

         ISSUE, WAIT: begin
            if (stb_q && !wb.i_wb_stall) begin
               if (issue_idx_q == n_req_q - 2'd1) begin
                  stb_d   = 1'b0;
                  state_d = WAIT;
               end else begin
                  issue_idx_d = next_idx;
                  we_d        = q_we_q[next_idx];
                  addr_d      = q_addr_q[next_idx];
                  wdata_d     = q_data_q[next_idx];
               end
            end

            // An ack on the threshold cycle takes priority over the timeout.
            if (wb.i_wb_ack) begin
               ack_cnt_d = ack_cnt_inc;
               tmo_d     = 8'd0;
               if (ack_cnt_inc == n_req_q) begin
                  cyc_d       = 1'b0;
                  stb_d       = 1'b0;
                  we_d        = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = wb.i_wb_data;
                  rsp_err_d   = 1'b0;
                  state_d     = RESP;
               end
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TMO_LIMIT) begin
                  cyc_d       = 1'b0;
                  stb_d       = 1'b0;
                  we_d        = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 8'h00;
                  rsp_err_d   = 1'b1;
                  state_d     = RESP;
               end
            end
         end

         RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         for (int i = 0; i < 3; i++) begin
            q_we_q[i]   <= 1'b0;
            q_addr_q[i] <= 8'h00;
            q_data_q[i] <= 8'h00;
         end
         n_req_q     <= 2'd0;
         issue_idx_q <= 2'd0;
         ack_cnt_q   <= 2'd0;
         tmo_q       <= 8'd0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         for (int i = 0; i < 3; i++) begin
            q_we_q[i]   <= q_we_d[i];
            q_addr_q[i] <= q_addr_d[i];
            q_data_q[i] <= q_data_d[i];
         end
         n_req_q     <= n_req_d;
         issue_idx_q <= issue_idx_d;
         ack_cnt_q   <= ack_cnt_d;
         tmo_q       <= tmo_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign o_req_ready  = (state_q == IDLE);
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_data   = rsp_data_q;
   assign o_rsp_err    = rsp_err_q;
   assign wb.o_wb_cyc  = cyc_q;
   assign wb.o_wb_stb  = stb_q;
   assign wb.o_wb_we   = we_q;
   assign wb.o_wb_addr = addr_q;
   assign wb.o_wb_data = wdata_q;

endmodule
